// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported fixed-latency memory between instruction
// fetch and data access, with in-flight fetch cancellation on branches.
module mem_port_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    output logic              if_stall,
    input  logic              mem_req,
    input  logic              mem_wr,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ack,
    output logic              mem_stall,
    output logic              m_en,
    output logic              m_wr,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              busy
);

    localparam int CW = $clog2(MEM_LAT + 1);
    localparam logic [CW-1:0] LAT = CW'(MEM_LAT);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          own;
    logic          drop;

    assign busy      = (state != IDLE);
    assign if_stall  = if_req & ~if_ack;
    assign mem_stall = mem_req & ~mem_ack;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            own       <= 1'b0;
            drop      <= 1'b0;
            m_en      <= 1'b0;
            m_wr      <= 1'b0;
            m_addr    <= '0;
            m_wdata   <= '0;
            if_ack    <= 1'b0;
            mem_ack   <= 1'b0;
            if_rdata  <= '0;
            mem_rdata <= '0;
        end else begin
            if_ack  <= 1'b0;
            mem_ack <= 1'b0;
            case (state)
                IDLE: begin
                    // Data access belongs to the older instruction, so it wins
                    if (mem_req) begin
                        m_addr  <= {mem_addr[ADDR_W-1:1], 1'b0};
                        m_wr    <= mem_wr;
                        m_wdata <= mem_wdata;
                        own     <= 1'b1;
                        drop    <= 1'b0;
                        m_en    <= 1'b1;
                        cnt     <= CW'(1);
                        state   <= BUSY;
                    end else if (if_req && !if_flush) begin
                        m_addr  <= {if_addr[ADDR_W-1:1], 1'b0};
                        m_wr    <= 1'b0;
                        m_wdata <= mem_wdata;
                        own     <= 1'b0;
                        drop    <= 1'b0;
                        m_en    <= 1'b1;
                        cnt     <= CW'(1);
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (!own && if_flush) begin
                        drop <= 1'b1;
                    end
                    if (cnt == LAT) begin
                        m_en  <= 1'b0;
                        m_wr  <= 1'b0;
                        state <= RESP;
                        // A flush in the final cycle must still cancel the fetch
                        if (!own && !drop && !if_flush) begin
                            if_rdata <= m_rdata;
                            if_ack   <= 1'b1;
                        end
                        if (own) begin
                            mem_ack <= 1'b1;
                            if (!m_wr) begin
                                mem_rdata <= m_rdata;
                            end
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-timing model
// that predicts each cycle's outputs from the grant cycle of the access.
module tb_mem_port_arbiter;

    localparam int L = 4;
    localparam int N = 4000;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [15:0] if_addr;
    logic        if_flush;
    logic [15:0] if_rdata;
    logic        if_ack;
    logic        if_stall;
    logic        mem_req;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic        mem_stall;
    logic        m_en;
    logic        m_wr;
    logic [15:0] m_addr;
    logic [15:0] m_wdata;
    logic [15:0] m_rdata;
    logic        busy;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W (16),
        .DATA_W (16),
        .MEM_LAT(L)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_flush (if_flush),
        .if_rdata (if_rdata),
        .if_ack   (if_ack),
        .if_stall (if_stall),
        .mem_req  (mem_req),
        .mem_wr   (mem_wr),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ack  (mem_ack),
        .mem_stall(mem_stall),
        .m_en     (m_en),
        .m_wr     (m_wr),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_rdata  (m_rdata),
        .busy     (busy)
    );

    // Environment memory seen by the DUT and an independent reference copy
    logic [15:0] mem     [256];
    logic [15:0] ref_mem [256];

    assign m_rdata = mem[m_addr[7:0]];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 20)
                $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic        act, own, wr, drop, post_rst;
    logic [15:0] addr, wdata, e_ifd, e_memd;
    logic        ack_i, ack_m, flush_p, rst_p;
    logic        e_en, e_wr, e_iack, e_mack;
    int          g, d;

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 16'($urandom);
            ref_mem[i] = mem[i];
        end
        rst       = 1'b1;
        if_req    = 1'b0;
        if_addr   = '0;
        if_flush  = 1'b0;
        mem_req   = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        act       = 1'b0;
        own       = 1'b0;
        wr        = 1'b0;
        drop      = 1'b0;
        addr      = '0;
        wdata     = '0;
        e_ifd     = '0;
        e_memd    = '0;
        post_rst  = 1'b1;
        ack_i     = 1'b0;
        ack_m     = 1'b0;
        flush_p   = 1'b0;
        rst_p     = 1'b1;
        g         = 0;
        repeat (2) @(posedge clk);

        for (int c = 0; c < N; c++) begin
            #1;
            rst      = ($urandom_range(0, 79) == 0);
            if_flush = ($urandom_range(0, 9) == 0);
            if (rst_p || flush_p || ack_i || !if_req) begin
                if_req  = ($urandom_range(0, 1) == 1);
                if_addr = 16'($urandom_range(0, 255));
            end
            if (rst_p || ack_m || !mem_req) begin
                mem_req   = ($urandom_range(0, 2) == 0);
                mem_wr    = 1'($urandom_range(0, 1));
                mem_addr  = 16'($urandom_range(0, 255));
                mem_wdata = 16'($urandom);
            end

            @(negedge clk);
            d      = c - g;
            e_en   = act && d >= 1 && d <= L;
            e_wr   = e_en && wr;
            e_iack = act && d == L + 1 && !own && !drop;
            e_mack = act && d == L + 1 && own;

            check("m_en", m_en, e_en);
            check("m_wr", m_wr, e_wr);
            check("busy", busy, act);
            check("if_ack", if_ack, e_iack);
            check("mem_ack", mem_ack, e_mack);
            check("if_stall", if_stall, if_req && !e_iack);
            check("mem_stall", mem_stall, mem_req && !e_mack);
            check("if_rdata", if_rdata, e_ifd);
            check("mem_rdata", mem_rdata, e_memd);
            if (e_en) check("m_addr", m_addr, addr);
            if (e_en && own) check("m_wdata", m_wdata, wdata);
            if (post_rst) begin
                check("rst_m_addr", m_addr, 0);
                check("rst_m_wdata", m_wdata, 0);
            end

            ack_i   = e_iack;
            ack_m   = e_mack;
            flush_p = if_flush;
            rst_p   = rst;

            if (m_en && m_wr) mem[m_addr[7:0]] = m_wdata;

            if (rst) begin
                act      = 1'b0;
                e_ifd    = '0;
                e_memd   = '0;
                post_rst = 1'b1;
            end else begin
                post_rst = 1'b0;
                if (act) begin
                    if (!own && if_flush) drop = 1'b1;
                    if (d == L) begin
                        if (!own && !drop) e_ifd = ref_mem[addr[7:0]];
                        if (own && !wr) e_memd = ref_mem[addr[7:0]];
                    end
                    if (d == L + 1) act = 1'b0;
                end else if (mem_req) begin
                    act   = 1'b1;
                    g     = c;
                    own   = 1'b1;
                    wr    = mem_wr;
                    addr  = {mem_addr[15:1], 1'b0};
                    wdata = mem_wdata;
                    drop  = 1'b0;
                    if (mem_wr) ref_mem[addr[7:0]] = mem_wdata;
                end else if (if_req && !if_flush) begin
                    act  = 1'b1;
                    g    = c;
                    own  = 1'b0;
                    wr   = 1'b0;
                    addr = {if_addr[15:1], 1'b0};
                    drop = 1'b0;
                end
            end
            @(posedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, fixed-latency unified memory between the IF stage (instruction fetch, read-only) and the MEM stage (data load/store) of the 5-stage pipeline.
- Arbitrates and sequences each transaction through a small FSM.
- Holds memory address and controls stable for the full access, returns data with a one-cycle ack, and drives stall signals to the hazard unit.
- Supports cancelling an in-flight fetch on a taken branch.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, data width.
- MEM_LAT, 4, cycles m_en is held before m_rdata is valid; must be >= 1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- if_req  in  1  fetch request, held until if_ack.
- if_addr  in  ADDR_W  fetch address.
- if_flush  in  1  cancel any pending or in-flight fetch.
- if_rdata  out  DATA_W  fetched instruction, valid with if_ack.
- if_ack  out  1  one-cycle completion pulse.
- if_stall  out  1  if_req & ~if_ack.
- mem_req  in  1  data request, held until mem_ack.
- mem_wr  in  1  1 = store, 0 = load.
- mem_addr  in  ADDR_W  data address.
- mem_wdata  in  DATA_W  store data.
- mem_rdata  out  DATA_W  load data, valid with mem_ack.
- mem_ack  out  1  one-cycle completion pulse.
- mem_stall  out  1  mem_req & ~mem_ack.
- m_en  out  1  memory enable.
- m_wr  out  1  memory write.
- m_addr  out  ADDR_W  memory address.
- m_wdata  out  DATA_W  memory write data.
- m_rdata  in  DATA_W  memory read data.
- busy  out  1  state != IDLE.

Behaviour:
- States: IDLE, BUSY, RESP. Counter cnt has width clog2(MEM_LAT+1). Owner register own: 0 = IF, 1 = MEM. Drop flag drop.
- Reset (rst=1 at a clock edge): state=IDLE, cnt=0, drop=0. All outputs 0: m_en, m_wr, m_addr, m_wdata, if_ack, mem_ack, if_rdata, mem_rdata. Any in-flight access is abandoned with no ack.
- IDLE arbitration, fixed priority MEM > IF (a data access belongs to the older instruction):
  - mem_req=1: grant MEM.
  - Otherwise if_req=1 and if_flush=0: grant IF.
  - Otherwise stay in IDLE.
- On grant (cycle t): register m_addr = addr with bit0 forced to 0; m_wr = mem_wr for MEM, 0 for IF; m_wdata = mem_wdata; own set; drop=0; m_en=1; cnt=1; next state BUSY.
- BUSY (cycles t+1 .. t+MEM_LAT):
  - m_en, m_wr, m_addr and m_wdata are held constant.
  - cnt increments each cycle.
  - When cnt == MEM_LAT: capture m_rdata into if_rdata (own=IF, drop=0) or mem_rdata (own=MEM, mem_wr=0), deassert m_en and m_wr, go to RESP.
- RESP (cycle t+MEM_LAT+1):
  - Registered ack: if_ack=1 if own=IF and drop=0; mem_ack=1 if own=MEM.
  - Requests are ignored this cycle, since the requester is still holding the request being acked.
  - Next state IDLE.
- Minimum transaction period is MEM_LAT+2 cycles. Ack is always exactly one cycle.
- Stores: mem_rdata keeps its previous value. mem_ack timing is identical to loads.
- if_flush:
  - Asserted in any cycle from IF grant through BUSY: sets drop=1. The memory access completes normally, but there is no if_ack and if_rdata is not updated.
  - Asserted in RESP: no effect; the ack is still issued.
  - Asserted in IDLE: blocks an IF grant that cycle.
  - Has no effect on MEM transactions.
- if_rdata and mem_rdata hold their value until the next capture.
- Requesters may change addr/data only after their ack. The arbiter uses only the latched values after grant.
- rst asserted in any state returns to IDLE on the next edge. It overrides RESP (no ack is issued).

Test Plan:
1. Memory word 0x0010 = 0x1234; if_req=1, if_addr=0x0010 at cycle 0 -> m_en=1 in cycles 1-4 with m_addr=0x0010; if_ack=1 and if_rdata=0x1234 in cycle 5 only; if_stall=1 in cycles 0-4, 0 in cycle 5.
2. if_req (0x0000) and mem_req load (0x0040 = 0xAAAA) both at cycle 0 -> mem_ack with 0xAAAA in cycle 5; IF granted in cycle 6; if_ack in cycle 11; if_stall=1 in cycles 0-10.
3. Store: mem_wr=1, mem_addr=0x0021, mem_wdata=0xBEEF -> m_addr=0x0020 and m_wr=1 in cycles 1-4; mem_ack in cycle 5; mem_rdata unchanged; a following load of 0x0020 returns 0xBEEF.
4. if_req at cycle 0 with if_flush pulsed in cycle 2 -> no if_ack ever; busy=0 in cycle 6; a new if_req (0x0100) raised in cycle 6 is acked in cycle 11 with the correct data.
5. rst pulsed in cycle 3 during an IF read -> in cycle 4: m_en=0, busy=0, if_ack=0, if_rdata=0; no ack is produced afterwards.
6. if_req held high over 3 transactions with mem_req=0 -> if_ack pulses in cycles 5, 11 and 17; MEM_LAT=1 configuration -> acks in cycles 2, 5 and 8.
